// File: rtl/spi_exe_pkg.sv
// Shared constants and state encoding for the SPI execution-unit slave.
// The frame is argA (M bits) + argB (M bits) + operation code (N bits).
package spi_exe_pkg;

  localparam int M    = 8;
  localparam int N    = 4;
  localparam int BITS = 2 * M + N;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SHIFT   = 3'd1,
    EXEC    = 3'd2,
    LOAD    = 3'd3,
    WAIT_HI = 3'd4
  } state_t;

endpackage

// File: rtl/spi_bit_counter.sv
// Saturating bit counter for the frame sequencer.
// Priority: clear, then load-one, then increment.
module spi_bit_counter #(
  parameter int CNT_W = 5,
  parameter int MAX   = 21
) (
  input  logic             sclk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load_one,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (load_one) begin
      cnt_reg <= CNT_W'(1);
    end else if (inc && (cnt_reg != MAX_CNT)) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/spi_frame_ctrl.sv
// Frame sequencer: counts shifted bits while i_cs is low, validates the frame
// length and runs capture -> execute -> result load, flagging collisions.
module spi_frame_ctrl
  import spi_exe_pkg::*;
#(
  parameter int BITS   = spi_exe_pkg::BITS,
  parameter int CNT_W  = $clog2(BITS + 2),
  parameter int FCNT_W = 8
) (
  input  logic              i_sclk,
  input  logic              i_rst,
  input  logic              i_cs,
  output logic              o_en,
  output logic              o_wrt_out,
  output logic              o_cap,
  output logic              o_done,
  output logic              o_frame_err,
  output logic              o_collision,
  output logic              o_busy,
  output logic [CNT_W-1:0]  o_bit_cnt,
  output logic [FCNT_W-1:0] o_frame_cnt,
  output logic [2:0]        o_state
);

  localparam logic [CNT_W-1:0] FRAME_LEN = CNT_W'(BITS);

  state_t             state_reg, state_next;
  logic               col_pend_reg, col_pend_next;
  logic               frame_err_reg;
  logic [FCNT_W-1:0]  frame_cnt_reg;
  logic [CNT_W-1:0]   bit_cnt;

  logic cnt_clear, cnt_load, cnt_inc;
  logic cap, wrt_out, done, collision;
  logic err_set, err_clr, fcnt_inc;

  spi_bit_counter #(
    .CNT_W (CNT_W),
    .MAX   (BITS + 1)
  ) u_bit_counter (
    .sclk     (i_sclk),
    .rst      (i_rst),
    .clear    (cnt_clear),
    .load_one (cnt_load),
    .inc      (cnt_inc),
    .cnt      (bit_cnt)
  );

  always_comb begin
    state_next    = state_reg;
    col_pend_next = col_pend_reg;
    cnt_clear     = 1'b0;
    cnt_load      = 1'b0;
    cnt_inc       = 1'b0;
    cap           = 1'b0;
    wrt_out       = 1'b0;
    done          = 1'b0;
    collision     = 1'b0;
    err_set       = 1'b0;
    err_clr       = 1'b0;
    fcnt_inc      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!i_cs) begin
          state_next = SHIFT;
          cnt_load   = 1'b1;
        end
      end
      SHIFT: begin
        if (!i_cs) begin
          cnt_inc = 1'b1;
        end else if (bit_cnt == FRAME_LEN) begin
          state_next = EXEC;
          err_clr    = 1'b1;
        end else begin
          state_next = IDLE;
          err_set    = 1'b1;
          cnt_clear  = 1'b1;
        end
      end
      EXEC: begin
        cap           = 1'b1;
        collision     = !i_cs;
        col_pend_next = !i_cs;
        state_next    = LOAD;
      end
      LOAD: begin
        wrt_out       = 1'b1;
        done          = 1'b1;
        fcnt_inc      = 1'b1;
        collision     = !i_cs;
        cnt_clear     = 1'b1;
        col_pend_next = 1'b0;
        // A collision from either EXEC or LOAD means the master is already mid-frame.
        state_next    = (col_pend_reg || !i_cs) ? WAIT_HI : IDLE;
      end
      WAIT_HI: begin
        if (i_cs) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_clear  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_sclk or negedge i_rst) begin
    if (!i_rst) begin
      state_reg     <= IDLE;
      col_pend_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      frame_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      col_pend_reg <= col_pend_next;
      if (err_set) begin
        frame_err_reg <= 1'b1;
      end else if (err_clr) begin
        frame_err_reg <= 1'b0;
      end
      if (fcnt_inc) begin
        frame_cnt_reg <= frame_cnt_reg + 1'b1;
      end
    end
  end

  // Mealy enable so bit 0 shifts on the same edge IDLE first sees i_cs low.
  assign o_en        = (!i_cs && ((state_reg == IDLE) || (state_reg == SHIFT))) ||
                       (state_reg == LOAD);
  assign o_wrt_out   = wrt_out;
  assign o_cap       = cap;
  assign o_done      = done;
  assign o_frame_err = frame_err_reg;
  assign o_collision = collision;
  assign o_busy      = (state_reg != IDLE);
  assign o_bit_cnt   = bit_cnt;
  assign o_frame_cnt = frame_cnt_reg;
  assign o_state     = state_reg;

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Scoreboard bench for spi_frame_ctrl: stimulus queues expected completions and
// collisions, a negedge monitor pops and compares them as the DUT reports them.
module tb_spi_frame_ctrl;

  localparam int BITS   = 20;
  localparam int CNT_W  = 5;
  localparam int FCNT_W = 8;

  logic              i_sclk = 1'b0;
  logic              i_rst  = 1'b0;
  logic              i_cs   = 1'b1;
  logic              o_en, o_wrt_out, o_cap, o_done;
  logic              o_frame_err, o_collision, o_busy;
  logic [CNT_W-1:0]  o_bit_cnt;
  logic [FCNT_W-1:0] o_frame_cnt;
  logic [2:0]        o_state;

  spi_frame_ctrl #(
    .BITS   (BITS),
    .CNT_W  (CNT_W),
    .FCNT_W (FCNT_W)
  ) dut (
    .i_sclk      (i_sclk),
    .i_rst       (i_rst),
    .i_cs        (i_cs),
    .o_en        (o_en),
    .o_wrt_out   (o_wrt_out),
    .o_cap       (o_cap),
    .o_done      (o_done),
    .o_frame_err (o_frame_err),
    .o_collision (o_collision),
    .o_busy      (o_busy),
    .o_bit_cnt   (o_bit_cnt),
    .o_frame_cnt (o_frame_cnt),
    .o_state     (o_state)
  );

  always #5 i_sclk = ~i_sclk;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_done_q[$];
  logic [2:0] exp_col_q[$];
  logic [7:0] model_fcnt = 8'd0;
  int         model_done = 0;
  int         done_seen  = 0;
  logic       last_cap   = 1'b0;
  logic [7:0] exp_f;
  logic [2:0] exp_s;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: every capture/done/collision must match a queued expectation.
  always @(negedge i_sclk) begin
    if (i_rst) begin
      if (o_cap) check("cap_expected", int'(exp_done_q.size() > 0), 1);
      if (o_done) begin
        done_seen++;
        check("done_expected", int'(exp_done_q.size() > 0), 1);
        if (exp_done_q.size() > 0) begin
          exp_f = exp_done_q.pop_front();
          check("done_frame_cnt", o_frame_cnt, exp_f);
          check("done_wrt_out", o_wrt_out, 1);
          check("done_en", o_en, 1);
          check("done_after_cap", last_cap, 1);
          $display("frame done: frame_cnt=%0d", o_frame_cnt);
        end
      end
      if (o_collision) begin
        check("collision_expected", int'(exp_col_q.size() > 0), 1);
        if (exp_col_q.size() > 0) begin
          exp_s = exp_col_q.pop_front();
          check("collision_state", o_state, exp_s);
          $display("collision in state %0d", o_state);
        end
      end
      last_cap = o_cap;
    end else begin
      last_cap = 1'b0;
    end
  end

  task automatic tick();
    @(posedge i_sclk);
    #1;
  endtask

  task automatic run_frame(input int nbits, input int gap, input bit good);
    int en_cnt;
    int exp_cnt;
    en_cnt  = 0;
    exp_cnt = (nbits > BITS + 1) ? BITS + 1 : nbits;
    if (good) begin
      exp_done_q.push_back(model_fcnt);
      model_fcnt++;
      model_done++;
    end
    i_cs = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      @(negedge i_sclk);
      if (o_en) en_cnt++;
      tick();
    end
    check("en_cycles", en_cnt, nbits);
    check("bit_cnt_end", o_bit_cnt, exp_cnt);
    i_cs = 1'b1;
    repeat (gap) tick();
    check("frame_err", o_frame_err, good ? 0 : 1);
  endtask

  initial begin
    #1;
    check("rst_state", o_state, 0);
    check("rst_bit_cnt", o_bit_cnt, 0);
    check("rst_frame_cnt", o_frame_cnt, 0);
    check("rst_frame_err", o_frame_err, 0);
    check("rst_en", o_en, 0);
    #11;
    i_rst = 1'b1;
    tick();

    // Good frame, then short, long and a recovering good frame.
    run_frame(20, 3, 1'b1);
    check("frame_cnt_after_first", o_frame_cnt, 1);
    $display("good frame: frame_cnt=%0d err=%0d", o_frame_cnt, o_frame_err);
    run_frame(19, 3, 1'b0);
    $display("19-bit frame: err=%0d", o_frame_err);
    run_frame(25, 3, 1'b0);
    $display("25-bit frame: err=%0d", o_frame_err);
    run_frame(20, 3, 1'b1);
    check("frame_cnt_after_recover", o_frame_cnt, 2);
    $display("recovery frame: err=%0d", o_frame_err);

    // Collision: i_cs high one cycle after a good frame, then low again.
    exp_done_q.push_back(model_fcnt);
    model_fcnt++;
    model_done++;
    exp_col_q.push_back(3'd2);
    exp_col_q.push_back(3'd3);
    i_cs = 1'b0;
    repeat (20) tick();
    i_cs = 1'b1;
    tick();
    i_cs = 1'b0;
    repeat (4) tick();
    check("col_wait_state", o_state, 4);
    check("col_wait_bit_cnt", o_bit_cnt, 0);
    check("col_wait_en", o_en, 0);
    check("col_wait_busy", o_busy, 1);
    check("col_frame_cnt", o_frame_cnt, 3);
    check("col_frame_err", o_frame_err, 0);
    i_cs = 1'b1;
    tick();
    check("col_exit_state", o_state, 0);
    $display("collision sequence: state=%0d frame_cnt=%0d", o_state, o_frame_cnt);
    repeat (2) tick();

    // Back-to-back frames with minimum gap, crossing the frame counter wrap.
    for (int f = 0; f < 256; f++) begin
      run_frame(20, 3, 1'b1);
    end
    check("wrap_frame_cnt", o_frame_cnt, model_fcnt);
    check("done_count", done_seen, model_done);
    check("collision_q_empty", exp_col_q.size(), 0);
    check("done_q_empty", exp_done_q.size(), 0);
    $display("after wrap: frame_cnt=%0d dones=%0d", o_frame_cnt, done_seen);

    // Async reset mid-frame.
    run_frame(5, 3, 1'b0);
    i_cs = 1'b0;
    repeat (7) tick();
    check("pre_rst_bit_cnt", o_bit_cnt, 7);
    #2;
    i_rst = 1'b0;
    i_cs  = 1'b1;
    #1;
    check("async_rst_state", o_state, 0);
    check("async_rst_bit_cnt", o_bit_cnt, 0);
    check("async_rst_en", o_en, 0);
    check("async_rst_frame_cnt", o_frame_cnt, 0);
    check("async_rst_frame_err", o_frame_err, 0);
    check("async_rst_busy", o_busy, 0);
    $display("async reset: state=%0d bit_cnt=%0d", o_state, o_bit_cnt);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
